// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, STATUS/CTRL bit indices and TX FSM state type for mmio_uart_tx
package uart_pkg;
   localparam logic [1:0] REG_TXDATA = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_BAUD   = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;
   localparam int ST_FULL      = 0;
   localparam int ST_EMPTY     = 1;
   localparam int ST_BUSY      = 2;
   localparam int ST_OVF       = 3;
   localparam int ST_LEVEL_LSB = 8;
   localparam int CTRL_EN      = 0;
   localparam int CTRL_IRQ     = 1;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; a push while full is accepted only when a pop happens in the same cycle
//   clk_i, resetn_i          : clock, asynchronous active-low reset (discards contents)
//   push_i, d_i              : push request and data
//   pop_i, q_o               : pop request and head-of-queue data
//   full_o, empty_o, level_o : occupancy flags and entry count
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                   clk_i,
   input  logic                   resetn_i,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       d_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       q_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] level_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0] wp_q, rp_q;
   logic [CW-1:0] cnt_q;
   logic do_push, do_pop;
   assign empty_o = cnt_q == '0;
   assign full_o  = cnt_q == CW'(DEPTH);
   assign level_o = cnt_q;
   assign q_o     = mem_q[rp_q];
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   always_ff @(posedge clk_i)
      if (do_push) mem_q[wp_q] <= d_i;
   always_ff @(posedge clk_i or negedge resetn_i)
      if (!resetn_i) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wp_q <= wp_q + AW'(1);
         if (do_pop) rp_q <= rp_q + AW'(1);
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO on the data-memory bus
//   clk_i, resetn_i      : clock, asynchronous active-low reset
//   cs_i, we_i, re_i     : chip select and write/read strobes (strobes qualified by cs_i)
//   ble_i, add_i, d_i    : byte-lane enables, byte offset ([3:2] selects register), write data
//   d_o                  : read data, registered one cycle after cs_i && re_i
//   tx_o                 : serial line, idles high
//   irq_o                : level interrupt, irq_en & FIFO empty & transmitter idle
import uart_pkg::*;
module mmio_uart_tx #(
   parameter int          FIFO_DEPTH   = 8,
   parameter logic [15:0] BAUD_DIV_RST = 16'd15
) (
   input  logic        clk_i,
   input  logic        resetn_i,
   input  logic        cs_i,
   input  logic        we_i,
   input  logic        re_i,
   input  logic [3:0]  ble_i,
   input  logic [3:0]  add_i,
   input  logic [31:0] d_i,
   output logic [31:0] d_o,
   output logic        tx_o,
   output logic        irq_o
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   tx_state_t state_q, state_d;
   logic [15:0] baud_q, cnt_q, cnt_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] sh_q, sh_d, fifo_q;
   logic [1:0] ctrl_q;
   logic [31:0] d_q, rdata, status;
   logic [LW-1:0] level;
   logic tx_q, tx_d, ovf_q, wr, push, pop, full, empty, busy, bit_end, unused_ok;
   assign unused_ok = ^{d_i[31:16], ble_i[3:2], add_i[1:0]};
   assign wr      = cs_i && we_i;
   assign push    = wr && add_i[3:2] == REG_TXDATA && ble_i[0];
   assign busy    = state_q != IDLE;
   // live compare against BAUDDIV so a smaller value written mid-bit ends the bit at once
   assign bit_end = cnt_q >= baud_q;
   assign tx_o    = tx_q;
   assign d_o     = d_q;
   assign irq_o   = ctrl_q[CTRL_IRQ] && empty && !busy;
   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .resetn_i(resetn_i),
      .push_i  (push),
      .d_i     (d_i[7:0]),
      .pop_i   (pop),
      .q_o     (fifo_q),
      .full_o  (full),
      .empty_o (empty),
      .level_o (level)
   );
   assign status = {16'h0, 8'(level), 4'h0, ovf_q, busy, empty, full};
   assign rdata  = add_i[3:2] == REG_STATUS ? status :
                   add_i[3:2] == REG_BAUD   ? {16'h0, baud_q} :
                   add_i[3:2] == REG_CTRL   ? {30'h0, ctrl_q} : '0;
   always_ff @(posedge clk_i or negedge resetn_i)
      if (!resetn_i) begin
         baud_q <= BAUD_DIV_RST;
         ctrl_q <= '0;
         ovf_q  <= 1'b0;
         d_q    <= '0;
      end else begin
         if (wr && add_i[3:2] == REG_BAUD && ble_i[0]) baud_q[7:0] <= d_i[7:0];
         if (wr && add_i[3:2] == REG_BAUD && ble_i[1]) baud_q[15:8] <= d_i[15:8];
         if (wr && add_i[3:2] == REG_CTRL && ble_i[0]) ctrl_q <= d_i[1:0];
         // a push into a full FIFO is only lost when nothing drains it in the same cycle
         if (push && full && !pop) ovf_q <= 1'b1;
         else if (wr && add_i[3:2] == REG_STATUS && ble_i[0] && d_i[ST_OVF]) ovf_q <= 1'b0;
         if (cs_i && re_i) d_q <= rdata;
      end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 16'd1;
      bit_d   = bit_q;
      sh_d    = sh_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            tx_d  = 1'b1;
            if (ctrl_q[CTRL_EN] && !empty) begin
               pop     = 1'b1;
               sh_d    = fifo_q;
               tx_d    = 1'b0;
               state_d = START;
            end
         end
         START: if (bit_end) begin
            cnt_d   = '0;
            bit_d   = '0;
            tx_d    = sh_q[0];
            state_d = DATA;
         end
         DATA: if (bit_end) begin
            cnt_d   = '0;
            bit_d   = bit_q + 3'd1;
            sh_d    = sh_q >> 1;
            tx_d    = bit_q == 3'd7 ? 1'b1 : sh_q[1];
            state_d = bit_q == 3'd7 ? STOP : DATA;
         end
         STOP: if (bit_end) begin
            cnt_d = '0;
            // chain straight into the next start bit so back-to-back frames have no gap
            if (ctrl_q[CTRL_EN] && !empty) begin
               pop     = 1'b1;
               sh_d    = fifo_q;
               tx_d    = 1'b0;
               state_d = START;
            end else begin
               tx_d    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or negedge resetn_i)
      if (!resetn_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         tx_q    <= tx_d;
      end
endmodule
